// File: rtl/maze_round_ctrl.sv
// Round sequencer for the maze game: idle, get-ready countdown, run, win/lose.
// Drives the BCD seconds timer enable, latches the final time and tracks the best win.
module maze_round_ctrl #(
    parameter int unsigned TICK_CLKS = 50_000_000,
    parameter int unsigned READY_SEC = 3,
    parameter logic [11:0] LIMIT_BCD = 12'h120
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Start,
    input  logic       i_Abort,
    input  logic       i_Goal,
    input  logic [3:0] i_Sec0,
    input  logic [3:0] i_Sec1,
    input  logic [3:0] i_Sec2,
    output logic       o_TmrEnable,
    output logic       o_MoveEn,
    output logic [2:0] o_State,
    output logic [1:0] o_Ready,
    output logic [3:0] o_Fin0,
    output logic [3:0] o_Fin1,
    output logic [3:0] o_Fin2,
    output logic [3:0] o_Best0,
    output logic [3:0] o_Best1,
    output logic [3:0] o_Best2,
    output logic       o_BestValid,
    output logic       o_NewRecord
);

    localparam int unsigned TickW = (TICK_CLKS > 2) ? $clog2(TICK_CLKS) : 1;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReady = 3'd1,
        StRun   = 3'd2,
        StWin   = 3'd3,
        StLose  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [TickW-1:0]  tick_q, tick_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [11:0]       fin_q, fin_d;
    logic [11:0]       best_q, best_d;
    logic              best_valid_q, best_valid_d;
    logic              new_record_q, new_record_d;

    logic [11:0]       sec_now;
    logic              tick_wrap;

    assign sec_now   = {i_Sec2, i_Sec1, i_Sec0};
    assign tick_wrap = (tick_q == TickW'(TICK_CLKS - 1));

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        cnt_d        = cnt_q;
        fin_d        = fin_q;
        best_d       = best_q;
        best_valid_d = best_valid_q;
        new_record_d = new_record_q;

        case (state_q)
            StIdle, StWin, StLose: begin
                if (i_Start) begin
                    state_d      = StReady;
                    tick_d       = '0;
                    cnt_d        = 2'(READY_SEC);
                    new_record_d = 1'b0;
                end
            end
            StReady: begin
                if (i_Abort) begin
                    state_d = StIdle;
                end else if (tick_wrap) begin
                    tick_d = '0;
                    if (cnt_q == 2'd1) begin
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end
            StRun: begin
                if (i_Abort) begin
                    state_d = StIdle;
                end else if (i_Goal) begin
                    state_d = StWin;
                    fin_d   = sec_now;
                    // Plain binary compare is valid because both operands are valid BCD.
                    if (!best_valid_q || (sec_now < best_q)) begin
                        best_d       = sec_now;
                        best_valid_d = 1'b1;
                        new_record_d = 1'b1;
                    end else begin
                        new_record_d = 1'b0;
                    end
                end else if (sec_now == LIMIT_BCD) begin
                    state_d = StLose;
                    fin_d   = sec_now;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q      <= StIdle;
            tick_q       <= '0;
            cnt_q        <= '0;
            fin_q        <= '0;
            best_q       <= '0;
            best_valid_q <= 1'b0;
            new_record_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            cnt_q        <= cnt_d;
            fin_q        <= fin_d;
            best_q       <= best_d;
            best_valid_q <= best_valid_d;
            new_record_q <= new_record_d;
        end
    end

    assign o_State     = state_q;
    assign o_TmrEnable = (state_q == StRun);
    assign o_MoveEn    = (state_q == StRun);
    assign o_Ready     = (state_q == StReady) ? cnt_q : 2'd0;
    assign o_Fin0      = fin_q[3:0];
    assign o_Fin1      = fin_q[7:4];
    assign o_Fin2      = fin_q[11:8];
    assign o_Best0     = best_q[3:0];
    assign o_Best1     = best_q[7:4];
    assign o_Best2     = best_q[11:8];
    assign o_BestValid = best_valid_q;
    assign o_NewRecord = new_record_q;

endmodule

// File: tb/tb_maze_round_ctrl.sv
// Bench for maze_round_ctrl: behavioural round model, BCD timer model and
// directed round scenarios with literal expectations.
module tb_maze_round_ctrl;

    localparam int unsigned TK  = 4;
    localparam int unsigned RS  = 3;
    localparam logic [11:0] LIM = 12'h005;

    logic        clk = 1'b0;
    logic        rst, start, abort, goal;
    logic [11:0] sec = '0;
    logic        tmr_en, move_en, best_valid, new_record;
    logic [2:0]  state;
    logic [1:0]  ready;
    logic [3:0]  fin0, fin1, fin2, best0, best1, best2;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    maze_round_ctrl #(
        .TICK_CLKS(TK),
        .READY_SEC(RS),
        .LIMIT_BCD(LIM)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Start    (start),
        .i_Abort    (abort),
        .i_Goal     (goal),
        .i_Sec0     (sec[3:0]),
        .i_Sec1     (sec[7:4]),
        .i_Sec2     (sec[11:8]),
        .o_TmrEnable(tmr_en),
        .o_MoveEn   (move_en),
        .o_State    (state),
        .o_Ready    (ready),
        .o_Fin0     (fin0),
        .o_Fin1     (fin1),
        .o_Fin2     (fin2),
        .o_Best0    (best0),
        .o_Best1    (best1),
        .o_Best2    (best2),
        .o_BestValid(best_valid),
        .o_NewRecord(new_record)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        for (int d = 0; d < 3; d++) begin
            if (r[d*4 +: 4] == 4'd9) begin
                r[d*4 +: 4] = 4'd0;
            end else begin
                r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                break;
            end
        end
        return r;
    endfunction

    // Fast timer: one BCD step per clock while enabled, clears while disabled.
    always @(posedge clk) begin
        if (!tmr_en) sec <= '0;
        else         sec <= bcd_inc(sec);
    end

    // Round model: phase number, cycles spent in the countdown, and the result registers.
    int          m_st = 0;
    int          m_el = 0;
    logic [11:0] m_fin = '0, m_best = '0;
    logic        m_bv = 1'b0, m_nr = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_st <= 0; m_el <= 0; m_fin <= '0; m_best <= '0; m_bv <= 1'b0; m_nr <= 1'b0;
        end else if (m_st == 1 || m_st == 2) begin
            if (abort) begin
                m_st <= 0;
            end else if (m_st == 1) begin
                if (m_el + 1 == int'(RS * TK)) m_st <= 2;
                else                           m_el <= m_el + 1;
            end else if (goal) begin
                m_st  <= 3;
                m_fin <= sec;
                if (!m_bv || sec < m_best) begin
                    m_best <= sec; m_bv <= 1'b1; m_nr <= 1'b1;
                end
            end else if (sec == LIM) begin
                m_st  <= 4;
                m_fin <= sec;
            end
        end else if (start) begin
            m_st <= 1; m_el <= 0; m_nr <= 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_state", int'(state), m_st);
            check("m_tmr_en", int'(tmr_en), int'(m_st == 2));
            check("m_move_en", int'(move_en), int'(m_st == 2));
            check("m_ready", int'(ready), (m_st == 1) ? int'(RS) - m_el / int'(TK) : 0);
            check("m_fin", int'({fin2, fin1, fin0}), int'(m_fin));
            check("m_best", int'({best2, best1, best0}), int'(m_best));
            check("m_best_valid", int'(best_valid), int'(m_bv));
            check("m_new_record", int'(new_record), int'(m_nr));
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic wait_state(input int st, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (int'(state) == st) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(name, int'(state), st);
    endtask

    task automatic wait_sec(input logic [11:0] t, input string name);
        for (int i = 0; i < 100; i++) begin
            if (sec == t && state == 3'd2) break;
            @(negedge clk);
        end
        check(name, int'(sec), int'(t));
    endtask

    task automatic goal_at(input logic [11:0] t);
        wait_sec(t, "goal_wait");
        goal = 1'b1;
        @(negedge clk);
        goal = 1'b0;
    endtask

    task automatic new_run();
        pulse_start();
        wait_state(2, "enter_run");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; goal = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        repeat (20) @(negedge clk);
        check("idle_state", int'(state), 0);
        check("idle_tmr", int'(tmr_en), 0);
        check("idle_ready", int'(ready), 0);
        check("idle_fin", int'({fin2, fin1, fin0}), 0);
        check("idle_bv", int'(best_valid), 0);

        pulse_start();
        for (int k = 0; k < 12; k++) begin
            check("cd_state", int'(state), 1);
            check("cd_ready", int'(ready), 3 - k / 4);
            @(negedge clk);
        end
        check("run_state", int'(state), 2);
        check("run_tmr", int'(tmr_en), 1);

        goal_at(12'h003);
        check("win1_state", int'(state), 3);
        check("win1_fin", int'({fin2, fin1, fin0}), 'h003);
        check("win1_best", int'({best2, best1, best0}), 'h003);
        check("win1_bv", int'(best_valid), 1);
        check("win1_nr", int'(new_record), 1);
        check("win1_tmr", int'(tmr_en), 0);

        new_run();
        goal_at(12'h004);
        check("slow_best", int'({best2, best1, best0}), 'h003);
        check("slow_nr", int'(new_record), 0);

        new_run();
        goal_at(12'h003);
        check("tie_best", int'({best2, best1, best0}), 'h003);
        check("tie_nr", int'(new_record), 0);

        new_run();
        goal_at(12'h002);
        check("rec_best", int'({best2, best1, best0}), 'h002);
        check("rec_nr", int'(new_record), 1);

        new_run();
        wait_state(4, "lose_state");
        check("lose_fin", int'({fin2, fin1, fin0}), 'h005);
        check("lose_best", int'({best2, best1, best0}), 'h002);

        new_run();
        goal_at(12'h005);
        check("both_state", int'(state), 3);
        check("both_fin", int'({fin2, fin1, fin0}), 'h005);

        pulse_start();
        repeat (2) @(negedge clk);
        pulse_abort();
        check("abr_rdy_state", int'(state), 0);
        check("abr_rdy_fin", int'({fin2, fin1, fin0}), 'h005);

        new_run();
        wait_sec(12'h001, "ign_wait");
        pulse_start();
        check("ign_start", int'(state), 2);
        pulse_abort();
        check("abr_run_state", int'(state), 0);
        check("abr_run_tmr", int'(tmr_en), 0);
        check("abr_run_best", int'({best2, best1, best0}), 'h002);

        new_run();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_state", int'(state), 0);
        check("rst_best", int'({best2, best1, best0}), 0);
        check("rst_bv", int'(best_valid), 0);
        check("rst_fin", int'({fin2, fin1, fin0}), 0);

        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
